// File: rtl/reg_scoreboard_if.sv
// Issue/writeback interface between decode/writeback logic and the register
// scoreboard.
//   master : decode + writeback side; drives the issue request, writeback
//            commit and flush, and receives issue_ready.
//   slave  : scoreboard side; the mirror image.
interface reg_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic [4:0] issue_rd;
  logic       issue_uses_rs1;
  logic       issue_uses_rs2;
  logic       issue_writes_rd;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
    output wb_valid, wb_rd, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
    input  wb_valid, wb_rd, flush,
    output issue_ready
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard for a 32x32 register file.
// It tracks the registers that have a write pending, and stalls issue on
// RAW and WAW hazards or when too many writes are outstanding.
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   sb           : issue/writeback/flush bundle (slave side)
//   busy_mask    : registered pending-write bit per register (bit 0 always 0)
//   inflight     : number of outstanding register writes
//   stall_cycles : saturating count of cycles with a request that was not granted
//   protocol_err : sticky; set when a writeback targets a register that is not busy
module reg_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  reg_scoreboard_if.slave    sb,
  output logic [31:0]        busy_mask,
  output logic [3:0]         inflight,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               protocol_err
);

  logic        raw;
  logic        waw;
  logic        full;
  logic        fire;
  logic        inc;
  logic        dec;
  logic        wb_err;
  logic        stall_event;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // The hazard check looks only at registered state. A writeback in this
  // cycle does not release its register until the following cycle, because
  // the register file itself only takes the write on this edge.
  always_comb begin
    raw  = (sb.issue_uses_rs1 & busy_mask[sb.issue_rs1]) |
           (sb.issue_uses_rs2 & busy_mask[sb.issue_rs2]);
    waw  = sb.issue_writes_rd & busy_mask[sb.issue_rd];
    full = sb.issue_writes_rd & (inflight == 4'(MAX_INFLIGHT));
  end

  // reset_n gates issue_ready so decode sees no grant while reset is held.
  assign sb.issue_ready = reset_n & ~raw & ~waw & ~full & ~sb.flush;

  // x0 is never tracked, so issue to rd=0 and writeback of rd=0 are both
  // no-ops. A writeback to a register that is not busy is a protocol error
  // and leaves the state unchanged.
  always_comb begin
    fire        = sb.issue_valid & sb.issue_ready;
    inc         = fire & sb.issue_writes_rd & (sb.issue_rd != 5'd0);
    dec         = sb.wb_valid & (sb.wb_rd != 5'd0) & busy_mask[sb.wb_rd];
    wb_err      = sb.wb_valid & (sb.wb_rd != 5'd0) & ~busy_mask[sb.wb_rd];
    stall_event = sb.issue_valid & ~sb.issue_ready;
    set_vec     = inc ? (32'd1 << sb.issue_rd) : 32'd0;
    clr_vec     = dec ? (32'd1 << sb.wb_rd) : 32'd0;
  end

  // The WAW check guarantees that set_vec and clr_vec never overlap, so
  // clearing and then setting yields the correct result. Flush overrides
  // everything else that happens in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_mask <= 32'd0;
      inflight  <= 4'd0;
    end else if (sb.flush) begin
      busy_mask <= 32'd0;
      inflight  <= 4'd0;
    end else begin
      busy_mask <= ((busy_mask & ~clr_vec) | set_vec) & ~32'd1;
      inflight  <= inflight + {3'd0, inc} - {3'd0, dec};
    end
  end

  // A writeback that arrives during a flush is killed along with the rest,
  // so it cannot raise the error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_err <= 1'b0;
    end else if (!sb.flush && wb_err) begin
      protocol_err <= 1'b1;
    end
  end

  // The counter includes flush cycles, because a request held during flush
  // counts as stalled. It sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall_event && (stall_cycles != {STALL_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard.
// Each table row is one clock cycle: the row's inputs are driven, and the
// outputs are checked before the edge. The expected busy_mask, inflight,
// stall_cycles and protocol_err values are the state at the start of that
// cycle. Hand-written sequences cover reset state, asynchronous reset in
// mid-operation and stall-counter saturation.
module tb_reg_scoreboard;

  logic        clk;
  logic        reset_n;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;
  logic [15:0] stall_cycles;
  logic        protocol_err;
  int          total;
  int          bad;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(
    .MAX_INFLIGHT (4),
    .STALL_W      (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sb           (sb_if.slave),
    .busy_mask    (busy_mask),
    .inflight     (inflight),
    .stall_cycles (stall_cycles),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        w;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        exp_ready;
    logic [31:0] exp_busy;
    logic [3:0]  exp_infl;
    logic [15:0] exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic u1, input logic u2, input logic w,
    input logic wbv, input logic [4:0] wbrd, input logic fl,
    input logic exp_ready, input logic [31:0] exp_busy,
    input logic [3:0] exp_infl, input logic [15:0] exp_stall,
    input logic exp_err);
    vec_t v;
    v.valid = valid;  v.rs1 = rs1;  v.rs2 = rs2;  v.rd = rd;
    v.u1 = u1;  v.u2 = u2;  v.w = w;
    v.wbv = wbv;  v.wbrd = wbrd;  v.fl = fl;
    v.exp_ready = exp_ready;  v.exp_busy = exp_busy;
    v.exp_infl = exp_infl;  v.exp_stall = exp_stall;  v.exp_err = exp_err;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    sb_if.issue_valid     = v.valid;
    sb_if.issue_rs1       = v.rs1;
    sb_if.issue_rs2       = v.rs2;
    sb_if.issue_rd        = v.rd;
    sb_if.issue_uses_rs1  = v.u1;
    sb_if.issue_uses_rs2  = v.u2;
    sb_if.issue_writes_rd = v.w;
    sb_if.wb_valid        = v.wbv;
    sb_if.wb_rd           = v.wbrd;
    sb_if.flush           = v.fl;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check_output({tag, " ready"}, 32'(sb_if.issue_ready), 32'(v.exp_ready));
    check_output({tag, " busy"},  busy_mask,              v.exp_busy);
    check_output({tag, " infl"},  32'(inflight),          32'(v.exp_infl));
    check_output({tag, " stall"}, 32'(stall_cycles),      32'(v.exp_stall));
    check_output({tag, " err"},   32'(protocol_err),      32'(v.exp_err));
  endtask

  // The occupancy count must always equal the number of busy registers,
  // and x0 must never be busy.
  always @(negedge clk) begin
    if (reset_n) begin
      total++;
      if ((32'(inflight) != 32'($countones(busy_mask))) || busy_mask[0]) begin
        bad++;
        $display("[TB] FAIL invariant: inflight=%0d busy_mask=0x%0h", inflight, busy_mask);
      end
    end
  end

  initial begin
    vec_t idle;
    vec_t cur;
    total = 0;
    bad   = 0;

    //         vld rs1 rs2 rd  u1 u2 w  wbv wbrd fl | rdy busy      infl stall err
    // Reset then idle; fire rd=5.
    vecs.push_back(mk(1, 3, 4, 5,  1, 1, 1, 0, 0, 0,  1, 32'h0,    0, 0, 0));
    // RAW on x5; writeback in C3 does not bypass.
    vecs.push_back(mk(1, 5, 0, 0,  1, 0, 0, 0, 0, 0,  0, 32'h20,   1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0,  1, 0, 0, 0, 0, 0,  0, 32'h20,   1, 1, 0));
    vecs.push_back(mk(1, 5, 0, 0,  1, 0, 0, 1, 5, 0,  0, 32'h20,   1, 2, 0));
    vecs.push_back(mk(1, 5, 0, 0,  1, 0, 0, 0, 0, 0,  1, 32'h0,    0, 3, 0));
    // WAW on x7.
    vecs.push_back(mk(1, 0, 0, 7,  0, 0, 1, 0, 0, 0,  1, 32'h0,    0, 3, 0));
    vecs.push_back(mk(1, 0, 0, 7,  0, 0, 1, 0, 0, 0,  0, 32'h80,   1, 3, 0));
    vecs.push_back(mk(1, 0, 0, 7,  0, 0, 1, 1, 7, 0,  0, 32'h80,   1, 4, 0));
    vecs.push_back(mk(1, 0, 0, 7,  0, 0, 1, 0, 0, 0,  1, 32'h0,    0, 5, 0));
    // x0 reads and writes never stall and are never tracked.
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 0, 0, 0,  1, 32'h80,   1, 5, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 0, 0, 0,  1, 32'h80,   1, 5, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1, 7, 0,  1, 32'h80,   1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 32'h0,    0, 5, 0));
    // Capacity: fill to 4.
    vecs.push_back(mk(1, 0, 0, 1,  0, 0, 1, 0, 0, 0,  1, 32'h0,    0, 5, 0));
    vecs.push_back(mk(1, 0, 0, 2,  0, 0, 1, 0, 0, 0,  1, 32'h2,    1, 5, 0));
    vecs.push_back(mk(1, 0, 0, 3,  0, 0, 1, 0, 0, 0,  1, 32'h6,    2, 5, 0));
    vecs.push_back(mk(1, 0, 0, 4,  0, 0, 1, 0, 0, 0,  1, 32'he,    3, 5, 0));
    vecs.push_back(mk(1, 0, 0, 6,  0, 0, 1, 0, 0, 0,  0, 32'h1e,   4, 5, 0));
    vecs.push_back(mk(1, 9, 0, 0,  1, 0, 0, 0, 0, 0,  1, 32'h1e,   4, 6, 0));
    vecs.push_back(mk(1, 0, 0, 6,  0, 0, 1, 1, 2, 0,  0, 32'h1e,   4, 6, 0));
    vecs.push_back(mk(1, 0, 0, 6,  0, 0, 1, 0, 0, 0,  1, 32'h1a,   3, 7, 0));
    // Simultaneous issue and writeback to different registers: net zero.
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 0,  1, 32'h5a,   4, 7, 0));
    vecs.push_back(mk(1, 0, 0, 10, 0, 0, 1, 1, 3, 0,  1, 32'h58,   3, 7, 0));
    // Flush with 3 in flight; then a stray writeback raises the error.
    vecs.push_back(mk(1, 0, 0, 11, 0, 0, 1, 0, 0, 1,  0, 32'h450,  3, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 8, 0,  1, 32'h0,    0, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 32'h0,    0, 8, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 32'h0,    0, 8, 1));

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);

    // Reset state: issue_ready is forced low while reset is held.
    reset_n = 1'b0;
    cur = mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    apply_stimulus(cur);
    @(negedge clk);
    check_all("reset", cur);
    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges with two writes outstanding.
    apply_stimulus(mk(1, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    @(posedge clk);
    #1 apply_stimulus(mk(1, 0, 0, 13, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    @(posedge clk);
    #1 apply_stimulus(mk(1, 0, 0, 14, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    #1;
    check_output("pre-rst infl", 32'(inflight), 32'd2);
    check_output("pre-rst busy", busy_mask, 32'h3000);
    check_output("pre-rst err", 32'(protocol_err), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    cur = mk(1, 0, 0, 14, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    check_all("async-rst", cur);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Stall-counter saturation: x5 stays busy and a WAW request is held.
    apply_stimulus(mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_output("sat busy", busy_mask, 32'h20);
    repeat (65534) @(posedge clk);
    #1;
    check_output("sat ready", 32'(sb_if.issue_ready), 32'd0);
    check_output("sat pre", 32'(stall_cycles), 32'hfffe);
    repeat (5000) @(posedge clk);
    #1;
    check_output("sat hold", 32'(stall_cycles), 32'hffff);

    apply_stimulus(idle);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
